csr_trap_seq: RTL and testbench

CSR access and trap sequencer: the initiator side of the machine-mode CSR register file's single write port and single combinational read port. It executes CSRRW/CSRRS/CSRRC and drives the multi-cycle ECALL/EBREAK entry and MRET return sequences as series of single CSR accesses. It returns old CSR values to the pipeline and issues PC redirects. It sits between the execute stage and the CSR register file.

---
 rtl/csr_trap_seq.sv | 219 +++++++++++++++++++++
 tb/tb_csr_trap_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_seq.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_seq
// Purpose  : Initiator for the machine-mode CSR file. Executes CSRRW/RS/RC and
//            sequences ECALL/EBREAK trap entry and MRET return as a series of
//            single-port CSR accesses, returning old values and PC redirects.
// Revision : 1.0  initial release
// ============================================================================
module csr_trap_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] src,
  input  logic [31:0] pc,
  output logic [11:0] csr_addr_r,
  input  logic [31:0] csr_rdata,
  output logic        csr_we,
  output logic [11:0] csr_addr_w,
  output logic [31:0] csr_wdata,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        illegal,
  output logic        busy
);

  localparam logic [2:0]  c_OP_CSRRW  = 3'd1;
  localparam logic [2:0]  c_OP_CSRRS  = 3'd2;
  localparam logic [2:0]  c_OP_CSRRC  = 3'd3;
  localparam logic [2:0]  c_OP_ECALL  = 3'd4;
  localparam logic [2:0]  c_OP_EBREAK = 3'd5;
  localparam logic [2:0]  c_OP_MRET   = 3'd6;

  localparam logic [11:0] c_MSTATUS   = 12'h300;
  localparam logic [11:0] c_MTVEC     = 12'h305;
  localparam logic [11:0] c_MEPC      = 12'h341;
  localparam logic [11:0] c_MCAUSE    = 12'h342;
  localparam logic [11:0] c_CSR_LO    = 12'h300;
  localparam logic [11:0] c_CSR_HI    = 12'h350;

  localparam logic [31:0] c_CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] c_CAUSE_EBREAK = 32'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CSR_WR   = 3'd1,
    S_T_EPC    = 3'd2,
    S_T_CAUSE  = 3'd3,
    S_T_STATUS = 3'd4,
    S_T_VEC    = 3'd5,
    S_R_STATUS = 3'd6,
    S_R_PC     = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] src_q, src_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] old_q, old_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        illegal_q, illegal_d;

  logic        w_in_range;
  logic [31:0] w_new_val;
  logic [31:0] w_status_trap;
  logic [31:0] w_status_ret;

  assign w_in_range = (csr_addr >= c_CSR_LO) && (csr_addr <= c_CSR_HI);

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M. Return: MIE <- MPIE, MPIE <- 1, MPP <- M.
  assign w_status_trap = {csr_rdata[31:13], 2'b11, csr_rdata[10:8], csr_rdata[3],
                          csr_rdata[6:4], 1'b0, csr_rdata[2:0]};
  assign w_status_ret  = {csr_rdata[31:13], 2'b11, csr_rdata[10:8], 1'b1,
                          csr_rdata[6:4], csr_rdata[7], csr_rdata[2:0]};

  // Read-modify-write result for the latched CSR instruction.
  always_comb begin
    w_new_val = src_q;
    unique case (op_q)
      c_OP_CSRRS: w_new_val = old_q | src_q;
      c_OP_CSRRC: w_new_val = old_q & ~src_q;
      default:    w_new_val = src_q;
    endcase
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign illegal  = illegal_q;

  // Next-state logic and state-decoded CSR port / redirect outputs.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    src_d          = src_q;
    pc_d           = pc_q;
    old_d          = old_q;
    rd_valid_d     = 1'b0;
    rd_data_d      = rd_data_q;
    illegal_d      = 1'b0;
    req_ready      = (state_q == S_IDLE);
    busy           = (state_q != S_IDLE);
    csr_addr_r     = csr_addr;
    csr_we         = 1'b0;
    csr_addr_w     = 12'h000;
    csr_wdata      = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = op;
          addr_d = csr_addr;
          src_d  = src;
          pc_d   = pc;
          old_d  = csr_rdata;
          unique case (op)
            c_OP_CSRRW, c_OP_CSRRS, c_OP_CSRRC: begin
              rd_valid_d = 1'b1;
              if (w_in_range) begin
                rd_data_d = csr_rdata;
                state_d   = S_CSR_WR;
              end else begin
                rd_data_d = 32'h0;
                illegal_d = 1'b1;
              end
            end
            c_OP_ECALL, c_OP_EBREAK: state_d = S_T_EPC;
            c_OP_MRET:               state_d = S_R_STATUS;
            default:                 state_d = S_IDLE;
          endcase
        end
      end
      S_CSR_WR: begin
        csr_addr_r = addr_q;
        csr_addr_w = addr_q;
        csr_wdata  = w_new_val;
        // Set/clear with a zero mask must not touch the CSR.
        csr_we     = (op_q == c_OP_CSRRW) || (src_q != 32'h0);
        state_d    = S_IDLE;
      end
      S_T_EPC: begin
        csr_addr_r = c_MEPC;
        csr_we     = 1'b1;
        csr_addr_w = c_MEPC;
        csr_wdata  = pc_q;
        state_d    = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        csr_addr_r = c_MCAUSE;
        csr_we     = 1'b1;
        csr_addr_w = c_MCAUSE;
        csr_wdata  = (op_q == c_OP_ECALL) ? c_CAUSE_ECALL : c_CAUSE_EBREAK;
        state_d    = S_T_STATUS;
      end
      S_T_STATUS: begin
        csr_addr_r = c_MSTATUS;
        csr_we     = 1'b1;
        csr_addr_w = c_MSTATUS;
        csr_wdata  = w_status_trap;
        state_d    = S_T_VEC;
      end
      S_T_VEC: begin
        csr_addr_r     = c_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[31:2], 2'b00};
        state_d        = S_IDLE;
      end
      S_R_STATUS: begin
        csr_addr_r = c_MSTATUS;
        csr_we     = 1'b1;
        csr_addr_w = c_MSTATUS;
        csr_wdata  = w_status_ret;
        state_d    = S_R_PC;
      end
      S_R_PC: begin
        csr_addr_r     = c_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[31:2], 2'b00};
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-request registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      addr_q     <= 12'h000;
      src_q      <= 32'h0;
      pc_q       <= 32'h0;
      old_q      <= 32'h0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      pc_q       <= pc_d;
      old_q      <= old_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_trap_seq
// Purpose  : Self-checking bench for csr_trap_seq with a CSR file model,
//            directed vectors, multi-cycle sequences and randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_csr_trap_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  op = 3'd0;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] src = 32'h0;
  logic [31:0] pc = 32'h0;
  logic [11:0] csr_addr_r;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csr_addr_w;
  logic [31:0] csr_wdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        illegal;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  // CSR file model: one write port, combinational read port, side preload port.
  logic [31:0] csr_mem [0:4095];
  logic [31:0] ref_csr [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'h0;
  logic [31:0] pl_data = 32'h0;

  always @(posedge clk) begin
    if (csr_we) csr_mem[csr_addr_w] <= csr_wdata;
    else if (pl_en) csr_mem[pl_addr] <= pl_data;
  end
  assign csr_rdata = csr_mem[csr_addr_r];

  always #5 clk = ~clk;

  csr_trap_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .csr_addr(csr_addr), .src(src), .pc(pc),
    .csr_addr_r(csr_addr_r), .csr_rdata(csr_rdata), .csr_we(csr_we),
    .csr_addr_w(csr_addr_w), .csr_wdata(csr_wdata), .rd_valid(rd_valid),
    .rd_data(rd_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .illegal(illegal), .busy(busy)
  );

  // Expected observable behaviour for one cycle after acceptance.
  typedef struct {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        rdv;
    logic [31:0] rdd;
    logic        ill;
    logic        redv;
    logic [31:0] redpc;
    logic        ready;
  } cyc_t;
  cyc_t exp_q[$];

  typedef struct {
    logic        pre_en;
    logic [31:0] pre_val;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    logic        e_we;
    logic [31:0] e_wdata;
    logic        e_rdv;
    logic [31:0] e_rdd;
    logic        e_ill;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic cyc_t idle_cyc();
    cyc_t c;
    c = '{default: '0};
    c.ready = 1'b1;
    return c;
  endfunction

  function automatic cyc_t wr_cyc(input logic [11:0] a, input logic [31:0] d);
    cyc_t c;
    c = '{default: '0};
    c.we = 1'b1; c.waddr = a; c.wdata = d;
    ref_csr[a] = d;
    return c;
  endfunction

  // Reference: what each instruction does to the CSR file and pipeline, cycle by cycle.
  function automatic void model(input logic [2:0] o, input logic [11:0] a,
                                input logic [31:0] s, input logic [31:0] p);
    cyc_t c;
    logic [31:0] st, old;
    exp_q.delete();
    c = idle_cyc();
    case (o)
      3'd1, 3'd2, 3'd3: begin
        if (a >= 12'h300 && a <= 12'h350) begin
          old = ref_csr[a];
          c.ready = 1'b0; c.rdv = 1'b1; c.rdd = old;
          if (o == 3'd1 || s != 0) begin
            c.we = 1'b1; c.waddr = a;
            c.wdata = (o == 3'd1) ? s : (o == 3'd2) ? (old | s) : (old & ~s);
            ref_csr[a] = c.wdata;
          end
        end else begin
          c.ill = 1'b1; c.rdv = 1'b1; c.rdd = 32'h0;
        end
        exp_q.push_back(c);
      end
      3'd4, 3'd5: begin
        exp_q.push_back(wr_cyc(12'h341, p));
        exp_q.push_back(wr_cyc(12'h342, (o == 3'd4) ? 32'd11 : 32'd3));
        st = ref_csr[12'h300];
        st[7] = st[3]; st[3] = 1'b0; st[12:11] = 2'b11;
        exp_q.push_back(wr_cyc(12'h300, st));
        c.ready = 1'b0; c.redv = 1'b1; c.redpc = ref_csr[12'h305] & 32'hFFFF_FFFC;
        exp_q.push_back(c);
      end
      3'd6: begin
        st = ref_csr[12'h300];
        st[3] = st[7]; st[7] = 1'b1; st[12:11] = 2'b11;
        exp_q.push_back(wr_cyc(12'h300, st));
        c.ready = 1'b0; c.redv = 1'b1; c.redpc = ref_csr[12'h341] & 32'hFFFF_FFFC;
        exp_q.push_back(c);
      end
      default: exp_q.push_back(c);
    endcase
    exp_q.push_back(idle_cyc());
  endfunction

  task automatic check_cycle(input cyc_t e, input string tag);
    chk({tag, " ready"}, {31'b0, req_ready}, {31'b0, e.ready});
    chk({tag, " busy"}, {31'b0, busy}, {31'b0, ~e.ready});
    chk({tag, " csr_we"}, {31'b0, csr_we}, {31'b0, e.we});
    if (e.we) begin
      chk({tag, " addr_w"}, {20'b0, csr_addr_w}, {20'b0, e.waddr});
      chk({tag, " wdata"}, csr_wdata, e.wdata);
    end
    chk({tag, " rd_valid"}, {31'b0, rd_valid}, {31'b0, e.rdv});
    if (e.rdv) chk({tag, " rd_data"}, rd_data, e.rdd);
    chk({tag, " illegal"}, {31'b0, illegal}, {31'b0, e.ill});
    chk({tag, " redirect_valid"}, {31'b0, redirect_valid}, {31'b0, e.redv});
    if (e.redv) chk({tag, " redirect_pc"}, redirect_pc, e.redpc);
  endtask

  task automatic drain(input string tag);
    int c = 1;
    while (exp_q.size() > 0) begin
      check_cycle(exp_q.pop_front(), $sformatf("%s c%0d", tag, c));
      c++;
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic pl(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    ref_csr[a] = d;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [11:0] a, input logic [31:0] s,
                        input logic [31:0] p, input string tag);
    int n = 0;
    model(o, a, s, p);
    @(negedge clk);
    op = o; csr_addr = a; src = s; pc = p; req_valid = 1'b1;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, " accept"}, {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    drain(tag);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_csr[i] = 32'h0;

    //        pre_en pre_val   op    addr     src       we  wdata     rdv rdd       ill
    tv[0] = '{1'b1, 32'h170,  3'd1, 12'h305, 32'h200,  1'b1, 32'h200,  1'b1, 32'h170,  1'b0};
    tv[1] = '{1'b1, 32'h1800, 3'd2, 12'h300, 32'h8,    1'b1, 32'h1808, 1'b1, 32'h1800, 1'b0};
    tv[2] = '{1'b0, 32'h0,    3'd3, 12'h300, 32'h0,    1'b0, 32'h0,    1'b1, 32'h1808, 1'b0};
    tv[3] = '{1'b0, 32'h0,    3'd1, 12'h7C0, 32'h55,   1'b0, 32'h0,    1'b1, 32'h0,    1'b1};
    tv[4] = '{1'b0, 32'h0,    3'd3, 12'h300, 32'h8,    1'b1, 32'h1800, 1'b1, 32'h1808, 1'b0};
    tv[5] = '{1'b1, 32'hF0,   3'd2, 12'h350, 32'h0F,   1'b1, 32'hFF,   1'b1, 32'hF0,   1'b0};
    tv[6] = '{1'b0, 32'h0,    3'd1, 12'h351, 32'h1,    1'b0, 32'h0,    1'b1, 32'h0,    1'b1};
    tv[7] = '{1'b0, 32'h0,    3'd3, 12'h2FF, 32'h1,    1'b0, 32'h0,    1'b1, 32'h0,    1'b1};
    tv[8] = '{1'b0, 32'h0,    3'd0, 12'h300, 32'h1,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0};
    tv[9] = '{1'b0, 32'h0,    3'd7, 12'h300, 32'h1,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset ready", {31'b0, req_ready}, 32'd1);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset csr_we", {31'b0, csr_we}, 32'd0);
    chk("reset redirect_pc", redirect_pc, 32'd0);
    rst = 1'b1;

    // Directed CSR vectors
    for (int i = 0; i < 10; i++) begin
      if (tv[i].pre_en) pl(tv[i].addr, tv[i].pre_val);
      model(tv[i].op, tv[i].addr, tv[i].src, 32'h0);
      exp_q.delete();
      @(negedge clk);
      op = tv[i].op; csr_addr = tv[i].addr; src = tv[i].src; req_valid = 1'b1;
      chk($sformatf("tv%0d accept", i), {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("tv%0d csr_we", i), {31'b0, csr_we}, {31'b0, tv[i].e_we});
      if (tv[i].e_we) begin
        chk($sformatf("tv%0d addr_w", i), {20'b0, csr_addr_w}, {20'b0, tv[i].addr});
        chk($sformatf("tv%0d wdata", i), csr_wdata, tv[i].e_wdata);
      end
      chk($sformatf("tv%0d rd_valid", i), {31'b0, rd_valid}, {31'b0, tv[i].e_rdv});
      if (tv[i].e_rdv) chk($sformatf("tv%0d rd_data", i), rd_data, tv[i].e_rdd);
      chk($sformatf("tv%0d illegal", i), {31'b0, illegal}, {31'b0, tv[i].e_ill});
      @(negedge clk);
      chk($sformatf("tv%0d rd_valid width", i), {31'b0, rd_valid}, 32'd0);
      chk($sformatf("tv%0d illegal width", i), {31'b0, illegal}, 32'd0);
      chk($sformatf("tv%0d ready after", i), {31'b0, req_ready}, 32'd1);
    end

    // ECALL with req_valid held: the follow-on CSRRS waits until the sequence ends
    pl(12'h300, 32'h1808);
    pl(12'h305, 32'h170);
    model(3'd4, 12'h0, 32'h0, 32'h1000);
    @(negedge clk);
    op = 3'd4; csr_addr = 12'h0; src = 32'h0; pc = 32'h1000; req_valid = 1'b1;
    chk("ecall accept", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    op = 3'd2; csr_addr = 12'h300; src = 32'h2; pc = 32'h0;
    drain("ecall_hold");
    model(3'd2, 12'h300, 32'h2, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    drain("held_rs");
    chk("ecall mepc", csr_mem[12'h341], 32'h1000);
    chk("ecall mcause", csr_mem[12'h342], 32'd11);
    chk("ecall+rs mstatus", csr_mem[12'h300], 32'h1882);

    // MRET and EBREAK
    pl(12'h300, 32'h1880);
    pl(12'h341, 32'h1000);
    run_op(3'd6, 12'h0, 32'h0, 32'h0, "mret");
    chk("mret mstatus", csr_mem[12'h300], 32'h1888);
    run_op(3'd5, 12'h0, 32'h0, 32'h2004, "ebreak");
    chk("ebreak mcause", csr_mem[12'h342], 32'd3);
    chk("ebreak mepc", csr_mem[12'h341], 32'h2004);

    // Reset during T_CAUSE
    pl(12'h342, 32'hABC);
    @(negedge clk);
    op = 3'd4; pc = 32'h3000; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; csr_addr = 12'h0;
    chk("rst epc we", {31'b0, csr_we}, 32'd1);
    @(negedge clk);
    chk("rst cause addr", {20'b0, csr_addr_w}, 32'h342);
    rst = 1'b0;
    #1;
    chk("rst mid csr_we", {31'b0, csr_we}, 32'd0);
    chk("rst mid addr_w", {20'b0, csr_addr_w}, 32'd0);
    chk("rst mid wdata", csr_wdata, 32'd0);
    chk("rst mid busy", {31'b0, busy}, 32'd0);
    chk("rst mid ready", {31'b0, req_ready}, 32'd1);
    chk("rst mid redirect", {31'b0, redirect_valid}, 32'd0);
    chk("rst mid rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst mid illegal", {31'b0, illegal}, 32'd0);
    chk("rst mid addr_r", {20'b0, csr_addr_r}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("rst mepc kept", csr_mem[12'h341], 32'h3000);
    chk("rst mcause unchanged", csr_mem[12'h342], 32'hABC);
    ref_csr[12'h341] = 32'h3000;

    // Randomized traffic against the reference model
    for (int a = 12'h300; a <= 12'h350; a++) pl(a[11:0], $urandom);
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  ro;
      logic [11:0] ra;
      logic [31:0] rs;
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) != 0) ? 12'(12'h300 + $urandom_range(0, 80))
                                       : 12'($urandom_range(0, 4095));
      rs = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run_op(ro, ra, rs, $urandom, $sformatf("rnd%0d", i));
    end
    for (int a = 12'h300; a <= 12'h350; a++)
      chk($sformatf("final csr %03h", a), csr_mem[a], ref_csr[a]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
